// File: rtl/uart_switch_pkg.sv
// Shared types and constants for the host/peripheral UART channel switch.
package uart_switch_pkg;

  typedef enum logic [1:0] {
    ACTIVE  = 2'd0,
    PENDING = 2'd1,
    GUARD   = 2'd2
  } state_e;

  localparam logic        MARK        = 1'b1;
  localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit flop synchroniser for an asynchronous input; reset value is parametrised
// so idle UART lines come out of reset at mark.
module sync_2ff
  import uart_switch_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stage_q;
  logic [SYNC_STAGES-1:0] stage_d;

  always_comb begin
    stage_d = {stage_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage_q <= {SYNC_STAGES{RESET_VAL}};
    else        stage_q <= stage_d;
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_channel_switch.sv
// Routes the host UART to one of NUM_CH peripheral UARTs, switching only after both
// directions have been idle, followed by a guard interval at mark.
module uart_channel_switch
  import uart_switch_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned SEL_W        = $clog2(NUM_CH),
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned IDLE_BITS    = 12,
  parameter int unsigned GUARD_BITS   = 1
) (
  input  logic              Clk,
  input  logic              ResetN,
  input  logic [SEL_W-1:0]  ChSelect,
  input  logic              HostTx,
  input  logic [NUM_CH-1:0] DevTx,
  output logic              HostRx,
  output logic [NUM_CH-1:0] DevRx,
  output logic [SEL_W-1:0]  ActiveCh,
  output logic              SwitchPending,
  output logic              SelErr
);

  localparam int unsigned IDLE_CYCLES  = IDLE_BITS * CLKS_PER_BIT;
  localparam int unsigned GUARD_CYCLES = GUARD_BITS * CLKS_PER_BIT;
  localparam int unsigned MAX_CYCLES   = (IDLE_CYCLES > GUARD_CYCLES) ? IDLE_CYCLES : GUARD_CYCLES;
  localparam int unsigned CNT_W        = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] IDLE_MAX   = CNT_W'(IDLE_CYCLES);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [SEL_W:0]   NUM_CH_X   = (SEL_W + 1)'(NUM_CH);

  logic              host_s;
  logic [NUM_CH-1:0] dev_s;
  logic [SEL_W-1:0]  sel_s;

  sync_2ff #(.RESET_VAL(MARK)) u_sync_host (
    .clk(Clk), .rst_n(ResetN), .d(HostTx), .q(host_s)
  );

  for (genvar g = 0; g < NUM_CH; g++) begin : g_sync_dev
    sync_2ff #(.RESET_VAL(MARK)) u_sync_dev (
      .clk(Clk), .rst_n(ResetN), .d(DevTx[g]), .q(dev_s[g])
    );
  end

  for (genvar g = 0; g < SEL_W; g++) begin : g_sync_sel
    sync_2ff #(.RESET_VAL(1'b0)) u_sync_sel (
      .clk(Clk), .rst_n(ResetN), .d(ChSelect[g]), .q(sel_s[g])
    );
  end

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  active_q, active_d;
  logic [SEL_W-1:0]  target_q, target_d;
  logic [CNT_W-1:0]  idle_q, idle_d;
  logic [CNT_W-1:0]  guard_q, guard_d;
  logic              host_rx_q, host_rx_d;
  logic [NUM_CH-1:0] dev_rx_q, dev_rx_d;
  logic              sel_err_q, sel_err_d;
  logic              sel_valid;
  logic              line_idle;

  always_comb begin
    sel_valid = ({1'b0, sel_s} < NUM_CH_X);
    line_idle = (idle_q == IDLE_MAX);
    state_d   = state_q;
    active_d  = active_q;
    target_d  = target_q;
    guard_d   = '0;
    sel_err_d = !sel_valid;

    if (host_s && dev_s[active_q]) idle_d = line_idle ? idle_q : idle_q + CNT_W'(1);
    else                           idle_d = '0;

    case (state_q)
      ACTIVE: begin
        if (sel_valid && (sel_s != active_q)) begin
          target_d = sel_s;
          state_d  = PENDING;
        end
      end
      PENDING: begin
        if (sel_valid && (sel_s == active_q)) begin
          state_d = ACTIVE;
        end else begin
          if (sel_valid) target_d = sel_s;
          // A retarget and idle in the same cycle switch straight to the new target.
          if (line_idle) begin
            state_d  = GUARD;
            active_d = target_d;
            idle_d   = '0;
          end
        end
      end
      GUARD: begin
        if (guard_q == GUARD_LAST) state_d = ACTIVE;
        else                       guard_d = guard_q + CNT_W'(1);
      end
      default: state_d = ACTIVE;
    endcase

    // Output gating follows the next state so the guard window aligns with GUARD exactly.
    host_rx_d = MARK;
    dev_rx_d  = '1;
    if (state_d != GUARD) begin
      host_rx_d = dev_s[active_d];
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (active_d == SEL_W'(i)) dev_rx_d[i] = host_s;
      end
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q   <= ACTIVE;
      active_q  <= '0;
      target_q  <= '0;
      idle_q    <= '0;
      guard_q   <= '0;
      host_rx_q <= MARK;
      dev_rx_q  <= '1;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      target_q  <= target_d;
      idle_q    <= idle_d;
      guard_q   <= guard_d;
      host_rx_q <= host_rx_d;
      dev_rx_q  <= dev_rx_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign HostRx        = host_rx_q;
  assign DevRx         = dev_rx_q;
  assign ActiveCh      = active_q;
  assign SwitchPending = (state_q != ACTIVE);
  assign SelErr        = sel_err_q;

endmodule

// File: tb/tb_uart_channel_switch.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, a negedge monitor checks them.
module tb_uart_channel_switch;

  localparam int K_HRX_A = 0;
  localparam int K_DRX_A = 1;
  localparam int K_AC_A  = 2;
  localparam int K_SP_A  = 3;
  localparam int K_SE_A  = 4;
  localparam int K_SE_B  = 5;
  localparam int K_AC_B  = 6;
  localparam int K_SP_B  = 7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] sel_a, sel_b;
  logic       htx_a, htx_b;
  logic [3:0] dtx_a;
  logic [2:0] dtx_b;
  logic       hrx_a, hrx_b;
  logic [3:0] drx_a;
  logic [2:0] drx_b;
  logic [1:0] ac_a, ac_b;
  logic       sp_a, sp_b, se_a, se_b;

  always #5 clk = ~clk;

  uart_channel_switch #(
    .NUM_CH(4), .CLKS_PER_BIT(4), .IDLE_BITS(2), .GUARD_BITS(1)
  ) dut_a (
    .Clk(clk), .ResetN(rst_n), .ChSelect(sel_a), .HostTx(htx_a), .DevTx(dtx_a),
    .HostRx(hrx_a), .DevRx(drx_a), .ActiveCh(ac_a), .SwitchPending(sp_a), .SelErr(se_a)
  );

  uart_channel_switch #(
    .NUM_CH(3), .CLKS_PER_BIT(4), .IDLE_BITS(2), .GUARD_BITS(1)
  ) dut_b (
    .Clk(clk), .ResetN(rst_n), .ChSelect(sel_b), .HostTx(htx_b), .DevTx(dtx_b),
    .HostRx(hrx_b), .DevRx(drx_b), .ActiveCh(ac_b), .SwitchPending(sp_b), .SelErr(se_b)
  );

  typedef struct {
    int unsigned due;
    int          kind;
    logic [7:0]  val;
    string       name;
  } chk_t;

  chk_t        sb[$];
  int unsigned cyc = 0;
  int unsigned total = 0;
  int unsigned passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] obs(input int k);
    case (k)
      K_HRX_A: return {7'b0, hrx_a};
      K_DRX_A: return {4'b0, drx_a};
      K_AC_A:  return {6'b0, ac_a};
      K_SP_A:  return {7'b0, sp_a};
      K_SE_A:  return {7'b0, se_a};
      K_SE_B:  return {7'b0, se_b};
      K_AC_B:  return {6'b0, ac_b};
      K_SP_B:  return {7'b0, sp_b};
      default: return 8'hxx;
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        total++;
        if (obs(sb[i].kind) === sb[i].val) passed++;
        else $display("FAIL %s @cyc %0d: got %0h expected %0h",
                      sb[i].name, cyc, obs(sb[i].kind), sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic chk(input int unsigned due, input int kind, input logic [7:0] v, input string n);
    chk_t c;
    c.due = due; c.kind = kind; c.val = v; c.name = n;
    sb.push_back(c);
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c;
    rst_n = 1'b0;
    sel_a = 2'd0; htx_a = 1'b1; dtx_a = 4'hF;
    sel_b = 2'd0; htx_b = 1'b1; dtx_b = 3'h7;

    // Reset state
    step(3);
    c = cyc;
    chk(c, K_HRX_A, 8'h1, "rst_hostrx");
    chk(c, K_DRX_A, 8'hF, "rst_devrx");
    chk(c, K_AC_A,  8'h0, "rst_activech");
    chk(c, K_SP_A,  8'h0, "rst_pending");
    chk(c, K_SE_A,  8'h0, "rst_selerr");
    total++;
    if (hrx_a === 1'b1) passed++;
    else $display("FAIL imm_rst_hostrx: got %0h", hrx_a);
    total++;
    if (drx_a === 4'hF) passed++;
    else $display("FAIL imm_rst_devrx: got %0h", drx_a);
    total++;
    if (ac_a === 2'd0) passed++;
    else $display("FAIL imm_rst_activech: got %0h", ac_a);
    total++;
    if (sp_a === 1'b0) passed++;
    else $display("FAIL imm_rst_pending: got %0h", sp_a);
    step(1);
    rst_n = 1'b1;

    // Invalid select on the 3-channel instance, then a valid switch
    step(10);
    c = cyc;
    sel_b = 2'd3;
    chk(c + 3, K_SE_B, 8'h1, "b_selerr_set");
    chk(c + 3, K_AC_B, 8'h0, "b_invalid_keep_ch");
    chk(c + 6, K_SP_B, 8'h0, "b_invalid_no_pending");
    chk(c + 6, K_AC_B, 8'h0, "b_invalid_keep_ch2");
    step(6);
    sel_b = 2'd1;
    chk(c + 9,  K_SE_B, 8'h0, "b_selerr_clear");
    chk(c + 9,  K_SP_B, 8'h1, "b_pending");
    chk(c + 10, K_AC_B, 8'h1, "b_switched");
    chk(c + 14, K_SP_B, 8'h0, "b_guard_done");
    step(10);

    // Channel 0 pass-through with 3-cycle latency
    c = cyc;
    dtx_a = 4'hE; htx_a = 1'b0;
    chk(c + 2, K_HRX_A, 8'h1, "t1_hostrx_before");
    chk(c + 3, K_HRX_A, 8'h0, "t1_hostrx_lat3");
    chk(c + 3, K_DRX_A, 8'hE, "t1_devrx0_only");
    chk(c + 3, K_AC_A,  8'h0, "t1_activech");
    step(1);
    dtx_a = 4'hF; htx_a = 1'b1;
    chk(c + 4, K_HRX_A, 8'h1, "t1_hostrx_back");
    chk(c + 4, K_DRX_A, 8'hF, "t1_devrx_back");
    step(12);

    // Idle switch 0 -> 2 with guard window
    c = cyc;
    sel_a = 2'd2;
    chk(c + 3, K_SP_A,  8'h1, "t2_pending");
    chk(c + 3, K_AC_A,  8'h0, "t2_ac_before");
    chk(c + 4, K_AC_A,  8'h2, "t2_ac_switched");
    chk(c + 4, K_SP_A,  8'h1, "t2_guard_pending");
    chk(c + 4, K_HRX_A, 8'h1, "t2_guard_hostrx");
    chk(c + 4, K_DRX_A, 8'hF, "t2_guard_devrx");
    step(2);
    htx_a = 1'b0;
    chk(c + 5, K_DRX_A, 8'hF, "t2_guard_masks_host");
    chk(c + 7, K_DRX_A, 8'hF, "t2_guard_last");
    chk(c + 7, K_SP_A,  8'h1, "t2_guard_last_pending");
    chk(c + 8, K_SP_A,  8'h0, "t2_active_again");
    chk(c + 8, K_DRX_A, 8'hB, "t2_devrx2_routed");
    chk(c + 8, K_AC_A,  8'h2, "t2_ac_final");
    step(6);
    htx_a = 1'b1; dtx_a = 4'hA;
    chk(c + 11, K_HRX_A, 8'h0, "t2_hostrx_from_ch2");
    chk(c + 11, K_DRX_A, 8'hF, "t2_devrx_mark");
    step(1);
    dtx_a = 4'hF;
    chk(c + 12, K_HRX_A, 8'h1, "t2_hostrx_back");
    step(12);

    // Switch request held off by a busy host frame
    c = cyc;
    sel_a = 2'd1;
    chk(c + 3, K_SP_A, 8'h1, "t3_pending");
    chk(c + 3, K_AC_A, 8'h2, "t3_ac_held");
    for (int k = 0; k < 4; k++) begin
      chk(c + 6 * k + 3, K_DRX_A, 8'hB, "t3_frame_bit");
      chk(c + 6 * k + 4, K_DRX_A, 8'hF, "t3_frame_mark");
      htx_a = 1'b0;
      step(1);
      htx_a = 1'b1;
      step(5);
    end
    chk(c + 29, K_AC_A, 8'h2, "t3_ac_until_idle");
    chk(c + 29, K_SP_A, 8'h1, "t3_pending_until_idle");
    chk(c + 30, K_AC_A, 8'h1, "t3_switched");
    chk(c + 30, K_DRX_A, 8'hF, "t3_guard_devrx");
    chk(c + 34, K_SP_A, 8'h0, "t3_guard_done");
    step(12);

    // Retarget and cancel while the device line is held low
    c = cyc;
    dtx_a = 4'hD; sel_a = 2'd3;
    chk(c + 3,  K_SP_A,  8'h1, "t4_pending");
    chk(c + 3,  K_AC_A,  8'h1, "t4_ac_held");
    chk(c + 3,  K_HRX_A, 8'h0, "t4_hostrx_low");
    step(4);
    sel_a = 2'd2;
    step(4);
    sel_a = 2'd1;
    chk(c + 10, K_SP_A,  8'h1, "t4_still_pending");
    chk(c + 11, K_SP_A,  8'h0, "t4_cancelled");
    chk(c + 11, K_AC_A,  8'h1, "t4_cancel_ac");
    chk(c + 12, K_HRX_A, 8'h0, "t4_no_guard");
    step(4);
    sel_a = 2'd3;
    chk(c + 15, K_SP_A,  8'h1, "t4_pending2");
    step(4);
    sel_a = 2'd0;
    chk(c + 24, K_SP_A,  8'h1, "t4_blocked_pending");
    chk(c + 24, K_AC_A,  8'h1, "t4_blocked_ac");
    step(4);
    dtx_a = 4'hF;
    chk(c + 30, K_AC_A,  8'h1, "t4_ac_until_idle");
    chk(c + 31, K_AC_A,  8'h0, "t4_retarget_switch");
    chk(c + 31, K_SP_A,  8'h1, "t4_guard_pending");
    chk(c + 35, K_SP_A,  8'h0, "t4_guard_done");
    chk(c + 35, K_AC_A,  8'h0, "t4_final_ac");
    step(22);

    // Asynchronous reset mid-guard
    c = cyc;
    sel_a = 2'd1;
    chk(c + 4, K_AC_A, 8'h1, "t6_in_guard_ac");
    chk(c + 4, K_SP_A, 8'h1, "t6_in_guard_sp");
    step(5);
    rst_n = 1'b0; sel_a = 2'd0;
    #1;
    total++;
    if (ac_a === 2'd0) passed++;
    else $display("FAIL imm_async_ac: got %0h", ac_a);
    total++;
    if (sp_a === 1'b0) passed++;
    else $display("FAIL imm_async_sp: got %0h", sp_a);
    total++;
    if (hrx_a === 1'b1) passed++;
    else $display("FAIL imm_async_hostrx: got %0h", hrx_a);
    total++;
    if (drx_a === 4'hF) passed++;
    else $display("FAIL imm_async_devrx: got %0h", drx_a);
    chk(c + 5, K_AC_A,  8'h0, "t6_async_ac");
    chk(c + 5, K_SP_A,  8'h0, "t6_async_sp");
    chk(c + 5, K_HRX_A, 8'h1, "t6_async_hostrx");
    chk(c + 5, K_DRX_A, 8'hF, "t6_async_devrx");
    step(2);
    rst_n = 1'b1;
    chk(c + 12, K_SP_A, 8'h0, "t6_no_switch_after_rst");
    chk(c + 12, K_AC_A, 8'h0, "t6_ch0_after_rst");
    step(8);

    // Asynchronous reset mid-frame
    c = cyc;
    dtx_a = 4'hE; htx_a = 1'b0;
    chk(c + 3, K_HRX_A, 8'h0, "t6_frame_hostrx");
    chk(c + 3, K_DRX_A, 8'hE, "t6_frame_devrx");
    step(4);
    rst_n = 1'b0;
    chk(c + 4, K_HRX_A, 8'h1, "t6_frame_rst_hostrx");
    chk(c + 4, K_DRX_A, 8'hF, "t6_frame_rst_devrx");
    step(1);
    rst_n = 1'b1;
    chk(c + 6, K_HRX_A, 8'h1, "t6_sync_reset_mark");
    chk(c + 8, K_HRX_A, 8'h0, "t6_resync_hostrx");
    chk(c + 8, K_DRX_A, 8'hE, "t6_resync_devrx");
    step(4);
    dtx_a = 4'hF; htx_a = 1'b1;
    step(6);

    foreach (sb[i]) begin
      total++;
      $display("FAIL %s: never checked, due cyc %0d, now cyc %0d", sb[i].name, sb[i].due, cyc);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_channel_switch.md
Name: uart_channel_switch

Overview:
Parametrised, clocked UART line router between the Raspberry Pi host UART and NUM_CH peripheral UARTs (Xbee, GPS, spares).
- Synchronises all asynchronous lines.
- Switches channels only when the line is idle, so no UART frame is ever truncated.
- Holds every deselected line at mark (logic 1).
- Sits in FlightControl between the RPi header pins and the radio/GPS module pins.

Parameters:
NUM_CH, 4, number of peripheral UART channels (>=2)
SEL_W, $clog2(NUM_CH), width of channel select
CLKS_PER_BIT, 434, Clk cycles per UART bit (50 MHz / 115200)
IDLE_BITS, 12, bit-times of continuous mark on both directions required before a switch
GUARD_BITS, 1, bit-times all routed outputs are forced to mark after a switch

Ports:
Clk  input  1  system clock
ResetN  input  1  asynchronous active-low reset
ChSelect  input  SEL_W  requested channel from RPi GPIO, asynchronous
HostTx  input  1  RPi UART Tx, asynchronous
DevTx  input  NUM_CH  peripheral UART Tx lines, asynchronous
HostRx  output  1  to RPi UART Rx
DevRx  output  NUM_CH  to peripheral UART Rx lines
ActiveCh  output  SEL_W  currently routed channel
SwitchPending  output  1  high while a requested switch waits for idle/guard
SelErr  output  1  high while the synchronised ChSelect >= NUM_CH

Behaviour:
- One clock domain, Clk. Reset is asynchronous, active-low (ResetN). Assertion takes effect immediately, with no clock edge, including mid-frame or mid-switch.
- Reset values: HostRx=1, DevRx=all 1, ActiveCh=0, SwitchPending=0, SelErr=0, state=ACTIVE, idle counter=0, guard counter=0.
- Synchronisers: HostTx, each DevTx bit and each ChSelect bit pass through 2 flops. Synchroniser flops reset to 1 for Tx lines and to 0 for ChSelect.
- Datapath, all outputs registered:
  - In ACTIVE or PENDING: HostRx <= sync DevTx[ActiveCh]; DevRx[ActiveCh] <= sync HostTx; every other DevRx bit <= 1.
  - Pin-to-pin latency is 3 Clk cycles.
- Idle counter:
  - Increments each cycle that sync HostTx==1 and sync DevTx[ActiveCh]==1.
  - Clears to 0 on any 0 on either line.
  - Saturates at IDLE_CYCLES = IDLE_BITS*CLKS_PER_BIT.
  - Line idle = counter == IDLE_CYCLES.
- Select validity:
  - SelErr = registered (sync ChSelect >= NUM_CH).
  - An invalid select is ignored. Routing and state are unchanged, and an in-progress PENDING keeps its last valid target.
- State machine:
  - ACTIVE: on a valid select != ActiveCh, latch target and go to PENDING.
  - PENDING (SwitchPending=1):
    - Valid select == ActiveCh: cancel, go to ACTIVE.
    - Valid select equals another channel: retarget, stay in PENDING. The idle counter is not cleared.
    - Line idle in the same cycle: go to GUARD. ActiveCh <= target (the retargeted value if both happen in one cycle). Idle counter cleared.
  - GUARD (SwitchPending=1): HostRx=1 and all DevRx=1 for GUARD_CYCLES = GUARD_BITS*CLKS_PER_BIT cycles, then go to ACTIVE. Select changes during GUARD are sampled on return to ACTIVE.
- If the select already matches on exit from reset, no switch occurs. Channel 0 is routed immediately after reset.
- A line held low forever (break or disconnected module) blocks switching indefinitely. This is required: there is no forced-switch path.
- Counter widths: $clog2(max(IDLE_CYCLES,GUARD_CYCLES)+1). No wrap; saturate.

Decomposition:
- Package uart_switch_pkg: state enum (ACTIVE, PENDING, GUARD), MARK=1'b1 constant, synchroniser stage count SYNC_STAGES=2.
- Sub-module sync_2ff: a single-bit synchroniser with a parametrised reset value, instantiated per async input bit.

Test Plan:
Use NUM_CH=4, CLKS_PER_BIT=4, IDLE_BITS=2, GUARD_BITS=1 (IDLE_CYCLES=8, GUARD_CYCLES=4).
1. Reset, ChSelect=0, toggle DevTx[0] -> HostRx follows 3 cycles later; DevRx[1..3]=1 throughout; ActiveCh=0.
2. Lines idle more than 8 cycles, ChSelect 0->2 -> SwitchPending=1 about 3 cycles later; GUARD 4 cycles with all outputs 1; then ActiveCh=2, HostTx appears on DevRx[2] only.
3. Continuous frame on HostTx (0 every 6 cycles), ChSelect 0->1 -> ActiveCh stays 0 with SwitchPending=1 until 8 idle cycles after the last 0; the frame's bits all appear on DevRx[0].
4. While PENDING, ChSelect 1->3 then 3->0 -> retarget to 3, then cancel: SwitchPending=0, ActiveCh=0, no GUARD period.
5. NUM_CH=3, ChSelect=3 -> SelErr=1, ActiveCh unchanged. Then ChSelect=1 -> SelErr=0, normal switch.
6. ResetN pulsed low mid-GUARD and mid-frame -> all outputs 1 and ActiveCh=0 asynchronously, before the next Clk edge.
